// File: rtl/clock_display_scan.sv
// clock_display_scan
// Time-multiplexed 8-digit common-anode 7-segment driver for the century
// clock. Digits are snapshotted on the seconds tick so a half-updated value
// is never rendered. The display alternates between a time page (HH MM SS)
// and a date page (DD MM YYYY). Each digit slot starts with one dark cycle
// to keep ghosting off the neighbouring digit.

module clock_display_scan #(
  parameter int SCAN_DIV = 1000,  // clk cycles per digit slot, >= 2
  parameter int PAGE_SEC = 5      // seconds each page stays up, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_s,
  input  logic       page_hold,
  input  logic [3:0] sec_unit,
  input  logic [3:0] sec_ten,
  input  logic [3:0] min_unit,
  input  logic [3:0] min_ten,
  input  logic [3:0] hour_unit,
  input  logic [3:0] hour_ten,
  input  logic [3:0] day_unit,
  input  logic [1:0] day_ten,
  input  logic [3:0] month_unit,
  input  logic [1:0] month_ten,
  input  logic [3:0] year_unit,
  input  logic [3:0] year_ten,
  input  logic [3:0] year_hund,
  input  logic [3:0] year_thou,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       page
);

  // Counter widths; a width of at least one bit keeps degenerate
  // parameter values legal.
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PAGE_W = (PAGE_SEC > 1) ? $clog2(PAGE_SEC) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_SEC - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Segment pattern {g,f,e,d,c,b,a}, active-low. Anything outside 0..9
  // renders as a dash so a corrupted digit is visible rather than silent.
  function automatic logic [6:0] seg_encode(input logic [3:0] val,
                                            input logic       blank);
    logic [6:0] code;
    if (blank) begin
      code = SEG_BLANK;
    end else begin
      case (val)
        4'd0:    code = 7'h40;
        4'd1:    code = 7'h79;
        4'd2:    code = 7'h24;
        4'd3:    code = 7'h30;
        4'd4:    code = 7'h19;
        4'd5:    code = 7'h12;
        4'd6:    code = 7'h02;
        4'd7:    code = 7'h78;
        4'd8:    code = 7'h00;
        4'd9:    code = 7'h10;
        default: code = SEG_DASH;
      endcase
    end
    return code;
  endfunction

  // Active-low one-hot anode for a digit index; all dark during dead-time.
  function automatic logic [7:0] anode_mask(input logic [2:0] digit,
                                            input logic       dark);
    logic [7:0] mask;
    if (dark) begin
      mask = 8'hFF;
    end else begin
      mask = ~(8'h01 << digit);
    end
    return mask;
  endfunction

  // Scan and page state
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        idx;
  logic [PAGE_W-1:0] page_cnt;
  logic              page_req;

  // Shadow copies of the clock digits, refreshed only on tick_s
  logic [3:0] sh_sec_unit;
  logic [3:0] sh_sec_ten;
  logic [3:0] sh_min_unit;
  logic [3:0] sh_min_ten;
  logic [3:0] sh_hour_unit;
  logic [3:0] sh_hour_ten;
  logic [3:0] sh_day_unit;
  logic [3:0] sh_day_ten;
  logic [3:0] sh_month_unit;
  logic [3:0] sh_month_ten;
  logic [3:0] sh_year_unit;
  logic [3:0] sh_year_ten;
  logic [3:0] sh_year_hund;
  logic [3:0] sh_year_thou;

  // Combinational next values
  logic       scan_wrap;
  logic       frame_wrap;
  logic       page_step;
  logic [3:0] digit_val;
  logic       digit_blank;
  logic       dp_on;
  logic [7:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // Slot and frame boundary detection
  always_comb begin
    scan_wrap  = (scan_cnt == SCAN_LAST);
    frame_wrap = scan_wrap && (idx == 3'd7);
    page_step  = tick_s && !page_hold;
  end

  // Pick the shadow digit, its blanking and the decimal point for the
  // current page and digit index
  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b1;
    dp_on       = 1'b0;
    if (page == 1'b0) begin
      case (idx)
        3'd0: begin
          digit_val   = sh_sec_unit;
          digit_blank = 1'b0;
        end
        3'd1: begin
          digit_val   = sh_sec_ten;
          digit_blank = 1'b0;
        end
        3'd2: begin
          digit_val   = sh_min_unit;
          digit_blank = 1'b0;
          dp_on       = ~sh_sec_unit[0];
        end
        3'd3: begin
          digit_val   = sh_min_ten;
          digit_blank = 1'b0;
        end
        3'd4: begin
          digit_val   = sh_hour_unit;
          digit_blank = 1'b0;
          dp_on       = ~sh_sec_unit[0];
        end
        3'd5: begin
          // Leading zero of the hour is suppressed
          digit_val   = sh_hour_ten;
          digit_blank = (sh_hour_ten == 4'd0);
        end
        default: begin
          digit_val   = 4'd0;
          digit_blank = 1'b1;
        end
      endcase
    end else begin
      case (idx)
        3'd0: digit_val = sh_year_unit;
        3'd1: digit_val = sh_year_ten;
        3'd2: digit_val = sh_year_hund;
        3'd3: digit_val = sh_year_thou;
        3'd4: begin
          digit_val = sh_month_unit;
          dp_on     = 1'b1;
        end
        3'd5: digit_val = sh_month_ten;
        3'd6: begin
          digit_val = sh_day_unit;
          dp_on     = 1'b1;
        end
        3'd7: digit_val = sh_day_ten;
        default: digit_val = 4'd0;
      endcase
      digit_blank = 1'b0;
    end
  end

  // Output pattern for the next cycle; dark anodes while scan_cnt is 0
  always_comb begin
    an_next  = anode_mask(idx, (scan_cnt == '0));
    seg_next = seg_encode(digit_val, digit_blank);
    dp_next  = ~dp_on;
  end

  // Scan prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Page timer: counts seconds unless held; toggles the requested page
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_cnt <= '0;
      page_req <= 1'b0;
    end else if (page_step) begin
      if (page_cnt == PAGE_LAST) begin
        page_cnt <= '0;
        page_req <= ~page_req;
      end else begin
        page_cnt <= page_cnt + PAGE_W'(1);
      end
    end else begin
      page_cnt <= page_cnt;
      page_req <= page_req;
    end
  end

  // Apply the requested page only when the scan wraps back to digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page <= 1'b0;
    end else if (frame_wrap) begin
      page <= page_req;
    end else begin
      page <= page;
    end
  end

  // Snapshot every clock digit on the seconds tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_sec_unit   <= 4'd0;
      sh_sec_ten    <= 4'd0;
      sh_min_unit   <= 4'd0;
      sh_min_ten    <= 4'd0;
      sh_hour_unit  <= 4'd0;
      sh_hour_ten   <= 4'd0;
      sh_day_unit   <= 4'd0;
      sh_day_ten    <= 4'd0;
      sh_month_unit <= 4'd0;
      sh_month_ten  <= 4'd0;
      sh_year_unit  <= 4'd0;
      sh_year_ten   <= 4'd0;
      sh_year_hund  <= 4'd0;
      sh_year_thou  <= 4'd0;
    end else if (tick_s) begin
      sh_sec_unit   <= sec_unit;
      sh_sec_ten    <= sec_ten;
      sh_min_unit   <= min_unit;
      sh_min_ten    <= min_ten;
      sh_hour_unit  <= hour_unit;
      sh_hour_ten   <= hour_ten;
      sh_day_unit   <= day_unit;
      sh_day_ten    <= {2'b00, day_ten};
      sh_month_unit <= month_unit;
      sh_month_ten  <= {2'b00, month_ten};
      sh_year_unit  <= year_unit;
      sh_year_ten   <= year_ten;
      sh_year_hund  <= year_hund;
      sh_year_thou  <= year_thou;
    end else begin
      sh_sec_unit   <= sh_sec_unit;
      sh_sec_ten    <= sh_sec_ten;
      sh_min_unit   <= sh_min_unit;
      sh_min_ten    <= sh_min_ten;
      sh_hour_unit  <= sh_hour_unit;
      sh_hour_ten   <= sh_hour_ten;
      sh_day_unit   <= sh_day_unit;
      sh_day_ten    <= sh_day_ten;
      sh_month_unit <= sh_month_unit;
      sh_month_ten  <= sh_month_ten;
      sh_year_unit  <= sh_year_unit;
      sh_year_ten   <= sh_year_ten;
      sh_year_hund  <= sh_year_hund;
      sh_year_thou  <= sh_year_thou;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n  <= 8'hFF;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_next;
      seg_n <= seg_next;
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed self-checking bench for clock_display_scan (SCAN_DIV=4, PAGE_SEC=2).
module tb_clock_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int PAGE_SEC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_s = 1'b0;
  logic       page_hold = 1'b0;
  logic [3:0] sec_unit = 4'd0, sec_ten = 4'd0, min_unit = 4'd0, min_ten = 4'd0;
  logic [3:0] hour_unit = 4'd0, hour_ten = 4'd0;
  logic [3:0] day_unit = 4'd0, month_unit = 4'd0;
  logic [1:0] day_ten = 2'd0, month_ten = 2'd0;
  logic [3:0] year_unit = 4'd0, year_ten = 4'd0, year_hund = 4'd0, year_thou = 4'd0;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       page;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] s;
  logic       d;
  logic       ok;
  logic [6:0] zero_seg [8];
  logic       zero_dp  [8];

  clock_display_scan #(.SCAN_DIV(SCAN_DIV), .PAGE_SEC(PAGE_SEC)) dut (
    .clk(clk), .rst(rst), .tick_s(tick_s), .page_hold(page_hold),
    .sec_unit(sec_unit), .sec_ten(sec_ten), .min_unit(min_unit), .min_ten(min_ten),
    .hour_unit(hour_unit), .hour_ten(hour_ten),
    .day_unit(day_unit), .day_ten(day_ten), .month_unit(month_unit), .month_ten(month_ten),
    .year_unit(year_unit), .year_ten(year_ten), .year_hund(year_hund), .year_thou(year_thou),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .page(page)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_time(input logic [3:0] ht, hu, mt, mu, st, su);
    hour_ten = ht; hour_unit = hu; min_ten = mt; min_unit = mu; sec_ten = st; sec_unit = su;
  endtask

  task automatic set_date(input logic [1:0] dt, input logic [3:0] du, input logic [1:0] mt,
                          input logic [3:0] mu, yth, yh, yt, yu);
    day_ten = dt; day_unit = du; month_ten = mt; month_unit = mu;
    year_thou = yth; year_hund = yh; year_ten = yt; year_unit = yu;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick_s = 1'b1;
    @(negedge clk);
    tick_s = 1'b0;
  endtask

  // Wait (bounded) for the first active cycle of digit dg and sample it
  task automatic sample_digit(input int dg, output logic [6:0] sg, output logic dpo);
    logic found;
    logic [7:0] target;
    found  = 1'b0;
    target = ~(8'h01 << dg);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an_n == target) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("slot_found", 32'(found), 32'd1);
    sg  = seg_n;
    dpo = dp_n;
  endtask

  // Wait (bounded) for page to take value v
  task automatic wait_page(input logic v, output logic found);
    found = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (page == v) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    // Shadows all zero: digits 0..4 show 0, hour_ten zero blanked, 6..7 blank
    for (int i = 0; i < 8; i++) begin
      zero_seg[i] = (i >= 5) ? 7'h7F : 7'h40;
      zero_dp[i]  = (i == 2 || i == 4) ? 1'b0 : 1'b1;
    end

    // ---------------- Reset and scan ----------------
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_an", 32'(an_n), 32'hFF);
    check_eq("rst_seg", 32'(seg_n), 32'h7F);
    check_eq("rst_dp", 32'(dp_n), 32'd1);
    check_eq("rst_page", 32'(page), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      int sc;
      int ix;
      logic [7:0] exp_an;
      @(negedge clk);
      sc = (k - 1) % SCAN_DIV;
      ix = ((k - 1) / SCAN_DIV) % 8;
      exp_an = (sc == 0) ? 8'hFF : ~(8'h01 << ix);
      check_eq($sformatf("scan_an_c%0d", k), 32'(an_n), 32'(exp_an));
      if (sc != 0) begin
        check_eq($sformatf("scan_seg_c%0d", k), 32'(seg_n), 32'(zero_seg[ix]));
        check_eq($sformatf("scan_dp_c%0d", k), 32'(dp_n), 32'(zero_dp[ix]));
      end
    end

    // ---------------- Time page render 23:59:58 ----------------
    set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
    pulse_tick();
    sample_digit(0, s, d); check_eq("t_idx0_seg", 32'(s), 32'h00); check_eq("t_idx0_dp", 32'(d), 32'd1);
    sample_digit(1, s, d); check_eq("t_idx1_seg", 32'(s), 32'h12);
    sample_digit(2, s, d); check_eq("t_idx2_seg", 32'(s), 32'h10); check_eq("t_idx2_dp", 32'(d), 32'd0);
    sample_digit(3, s, d); check_eq("t_idx3_seg", 32'(s), 32'h12); check_eq("t_idx3_dp", 32'(d), 32'd1);
    sample_digit(4, s, d); check_eq("t_idx4_seg", 32'(s), 32'h30); check_eq("t_idx4_dp", 32'(d), 32'd0);
    sample_digit(5, s, d); check_eq("t_idx5_seg", 32'(s), 32'h24);
    sample_digit(6, s, d); check_eq("t_idx6_seg", 32'(s), 32'h7F);
    sample_digit(7, s, d); check_eq("t_idx7_seg", 32'(s), 32'h7F);
    // Input change without a tick must not reach the display
    sec_unit = 4'd3;
    sample_digit(0, s, d); check_eq("t_no_tick_seg", 32'(s), 32'h00);

    // ---------------- Blanking and blink 09:05:07 ----------------
    do_reset();
    sample_digit(1, s, d); check_eq("b_shadow_cleared", 32'(s), 32'h40);
    set_time(4'd0, 4'd9, 4'd0, 4'd5, 4'd0, 4'd7);
    pulse_tick();
    sample_digit(0, s, d); check_eq("b_idx0_seg", 32'(s), 32'h78);
    sample_digit(2, s, d); check_eq("b_idx2_seg", 32'(s), 32'h12); check_eq("b_idx2_dp", 32'(d), 32'd1);
    sample_digit(4, s, d); check_eq("b_idx4_seg", 32'(s), 32'h10); check_eq("b_idx4_dp", 32'(d), 32'd1);
    sample_digit(5, s, d); check_eq("b_idx5_seg", 32'(s), 32'h7F);

    // ---------------- Page switch 31-12-2099 ----------------
    do_reset();
    set_date(2'd3, 4'd1, 2'd1, 4'd2, 4'd2, 4'd0, 4'd9, 4'd9);
    pulse_tick();
    pulse_tick();
    check_eq("p_still_time", 32'(page), 32'd0);
    wait_page(1'b1, ok);
    check_eq("p_to_date_found", 32'(ok), 32'd1);
    check_eq("p_switch_at_wrap_an", 32'(an_n), 32'h7F);
    sample_digit(7, s, d); check_eq("d_idx7_seg", 32'(s), 32'h30); check_eq("d_idx7_dp", 32'(d), 32'd1);
    sample_digit(6, s, d); check_eq("d_idx6_seg", 32'(s), 32'h79); check_eq("d_idx6_dp", 32'(d), 32'd0);
    sample_digit(4, s, d); check_eq("d_idx4_seg", 32'(s), 32'h24); check_eq("d_idx4_dp", 32'(d), 32'd0);
    sample_digit(3, s, d); check_eq("d_idx3_seg", 32'(s), 32'h24);
    sample_digit(2, s, d); check_eq("d_idx2_seg", 32'(s), 32'h40); check_eq("d_idx2_dp", 32'(d), 32'd1);
    sample_digit(1, s, d); check_eq("d_idx1_seg", 32'(s), 32'h10);
    sample_digit(0, s, d); check_eq("d_idx0_seg", 32'(s), 32'h10);
    pulse_tick();
    pulse_tick();
    check_eq("p_still_date", 32'(page), 32'd1);
    wait_page(1'b0, ok);
    check_eq("p_back_time_found", 32'(ok), 32'd1);
    check_eq("p_back_at_wrap_an", 32'(an_n), 32'h7F);

    // ---------------- Hold ----------------
    do_reset();
    pulse_tick();                      // page_cnt = 1
    @(negedge clk);
    page_hold = 1'b1;                  // hold rises with the terminal tick
    tick_s = 1'b1;
    @(negedge clk);
    tick_s = 1'b0;
    repeat (5) pulse_tick();
    repeat (40) @(negedge clk);
    check_eq("h_page_held", 32'(page), 32'd0);
    page_hold = 1'b0;
    pulse_tick();                      // count still 1: this one toggles
    repeat (40) @(negedge clk);
    check_eq("h_release_tick1", 32'(page), 32'd1);
    pulse_tick();
    repeat (40) @(negedge clk);
    check_eq("h_release_tick2", 32'(page), 32'd1);
    pulse_tick();
    repeat (40) @(negedge clk);
    check_eq("h_release_tick3", 32'(page), 32'd0);

    // ---------------- Invalid BCD and reset mid-frame ----------------
    do_reset();
    set_time(4'd0, 4'd0, 4'd0, 4'hC, 4'd0, 4'd0);
    pulse_tick();
    sample_digit(2, s, d); check_eq("i_dash_seg", 32'(s), 32'h3F); check_eq("i_dash_dp", 32'(d), 32'd0);
    pulse_tick();
    wait_page(1'b1, ok);
    check_eq("i_date_found", 32'(ok), 32'd1);
    sample_digit(5, s, d);
    rst = 1'b1;
    #1;
    check_eq("m_rst_an", 32'(an_n), 32'hFF);
    check_eq("m_rst_seg", 32'(seg_n), 32'h7F);
    check_eq("m_rst_page", 32'(page), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("m_restart_dark", 32'(an_n), 32'hFF);
    @(negedge clk);
    check_eq("m_restart_idx0", 32'(an_n), 32'hFE);
    check_eq("m_restart_page", 32'(page), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
